// File: rtl/lc3b_mem_port.sv
// lc3b_mem_port: handshaked load/store port for the LC-3b datapath.
// Accepts one word/byte request, drives the memory bus until mem_resp,
// aligns/extends load data and holds the response until it is consumed.
// Optional build macro: MEM_PORT_TIMEOUT_EN (bounds the wait for mem_resp).
`timescale 1ns/1ps

module lc3b_mem_port #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned LANES       = DATA_W / 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [LANES-1:0]  mem_byte_enable,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int unsigned LANE_W = $clog2(LANES);

  // Reject parameter combinations the datapath cannot represent.
  if ((DATA_W != 16 && DATA_W != 32) || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535)
  begin : g_bad_param
    $error("lc3b_mem_port: illegal DATA_W or TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e              state_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                resp_err_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [LANES-1:0]    mem_be_q;
  logic [LANE_W-1:0]   lane_q;
  logic                byte_q;
  logic                write_q;

  logic [LANE_W-1:0]   lane_c;
  logic                misaligned_c;
  logic [ADDR_W-1:0]   addr_aligned_c;
  logic [LANES-1:0]    be_onehot_c;
  logic [7:0]          byte_sel_c;
  logic [DATA_W-1:0]   load_data_c;
  logic                tmo_expire_c;

  // Request decode: lane, alignment, word address and byte-lane enable.
  assign lane_c         = req_addr[LANE_W-1:0];
  assign misaligned_c   = !req_byte && (lane_c != '0);
  assign addr_aligned_c = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  assign be_onehot_c    = LANES'(1) << lane_c;

  // Pick the addressed byte lane out of the returned word.
  always_comb begin
    byte_sel_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) byte_sel_c = mem_rdata[8*i +: 8];
    end
    load_data_c = byte_q ? DATA_W'(byte_sel_c) : mem_rdata;
  end

`ifdef MEM_PORT_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  // Cycles spent in ACCESS; zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  tmo_cnt_q <= '0;
    else if (state_q != S_ACCESS) tmo_cnt_q <= '0;
    else                         tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  assign tmo_expire_c = (state_q == S_ACCESS) && (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));
`else
  assign tmo_expire_c = 1'b0;
`endif

  // Port FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      lane_q        <= '0;
      byte_q        <= 1'b0;
      write_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!req_ready_q) begin
            // One settling cycle after a response keeps requests 3 cycles apart.
            req_ready_q <= 1'b1;
          end else if (req_valid) begin
            req_ready_q <= 1'b0;
            lane_q      <= lane_c;
            byte_q      <= req_byte;
            write_q     <= req_write;
            if (misaligned_c) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q       <= S_ACCESS;
              mem_address_q <= addr_aligned_c;
              mem_read_q    <= !req_write;
              mem_write_q   <= req_write;
              if (!req_write) begin
                mem_wdata_q <= '0;
                mem_be_q    <= '0;
              end else if (req_byte) begin
                mem_wdata_q <= {LANES{req_wdata[7:0]}};
                mem_be_q    <= be_onehot_c;
              end else begin
                mem_wdata_q <= req_wdata;
                mem_be_q    <= '1;
              end
            end
          end
        end
        S_ACCESS: begin
          if (mem_resp) begin
            state_q      <= S_RESP;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= write_q ? '0 : load_data_c;
          end else if (tmo_expire_c) begin
            state_q      <= S_RESP;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_err        = resp_err_q;
  assign mem_address     = mem_address_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;

endmodule

// File: tb/tb_lc3b_mem_port.sv
// Bench for lc3b_mem_port: a 16-bit and a 32-bit instance share one set of
// stimulus signals; 'sel' chooses which instance sees the handshakes.
`timescale 1ns/1ps

module tb_lc3b_mem_port;

  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sel;
  logic        req_valid, req_write, req_byte, resp_ready, mem_resp;
  logic [15:0] req_addr;
  logic [31:0] req_wdata, mem_rdata;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_read, a_mem_write;
  logic [15:0] a_resp_rdata, a_mem_address, a_mem_wdata;
  logic [1:0]  a_be;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_read, b_mem_write;
  logic [31:0] b_resp_rdata, b_mem_wdata;
  logic [15:0] b_mem_address;
  logic [3:0]  b_be;

  lc3b_mem_port #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYC(TMO)) u_p16 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr),
    .req_wdata(req_wdata[15:0]),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready & ~sel),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .mem_address(a_mem_address), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_wdata(a_mem_wdata), .mem_byte_enable(a_be),
    .mem_rdata(mem_rdata[15:0]), .mem_resp(mem_resp & ~sel)
  );

  lc3b_mem_port #(.DATA_W(32), .ADDR_W(16), .TIMEOUT_CYC(TMO)) u_p32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready & sel),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .mem_address(b_mem_address), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_wdata(b_mem_wdata), .mem_byte_enable(b_be),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp & sel)
  );

  // View of whichever instance is selected.
  wire        o_req_ready  = sel ? b_req_ready  : a_req_ready;
  wire        o_resp_valid = sel ? b_resp_valid : a_resp_valid;
  wire        o_resp_err   = sel ? b_resp_err   : a_resp_err;
  wire        o_mem_read   = sel ? b_mem_read   : a_mem_read;
  wire        o_mem_write  = sel ? b_mem_write  : a_mem_write;
  wire [31:0] o_resp_rdata = sel ? b_resp_rdata : {16'h0, a_resp_rdata};
  wire [15:0] o_mem_addr   = sel ? b_mem_address : a_mem_address;
  wire [31:0] o_mem_wdata  = sel ? b_mem_wdata  : {16'h0, a_mem_wdata};
  wire [3:0]  o_be         = sel ? b_be         : {2'b00, a_be};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  typedef struct {
    bit          s, w, b;
    logic [15:0] addr;
    logic [31:0] wd, rd;
    int          dly, hold;
    bit          mis;
    logic [31:0] e_rdata;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  function automatic vec_t mk(bit s, bit w, bit b, logic [15:0] addr, logic [31:0] wd,
                              logic [31:0] rd, int dly, int hold, bit mis,
                              logic [31:0] e_rdata, logic [15:0] e_addr,
                              logic [31:0] e_wdata, logic [3:0] e_be);
    vec_t v;
    v.s = s; v.w = w; v.b = b; v.addr = addr; v.wd = wd; v.rd = rd;
    v.dly = dly; v.hold = hold; v.mis = mis; v.e_rdata = e_rdata;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_be = e_be;
    return v;
  endfunction

  // Reference: expected bus/response values from the access rules, by arithmetic.
  function automatic vec_t model(bit s, bit w, bit b, logic [15:0] addr, logic [31:0] wd,
                                 logic [31:0] rd, int dly, int hold);
    vec_t v;
    int lanes = s ? 4 : 2;
    int k = int'(addr) % lanes;
    logic [31:0] mask = s ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    v.s = s; v.w = w; v.b = b; v.addr = addr; v.wd = wd; v.rd = rd;
    v.dly = dly; v.hold = hold;
    v.mis    = !b && (k != 0);
    v.e_addr = addr - 16'(k);
    v.e_be   = b ? 4'(1 << k) : 4'((1 << lanes) - 1);
    v.e_wdata = b ? (32'(wd[7:0]) * (s ? 32'h0101_0101 : 32'h0000_0101)) : (wd & mask);
    if (w || v.mis) v.e_rdata = 32'h0;
    else if (b)     v.e_rdata = (rd >> (8 * k)) & 32'hFF;
    else            v.e_rdata = rd & mask;
    return v;
  endfunction

  // Consume a held response and check the ready spacing afterwards.
  task automatic release_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_valid_drop", o_resp_valid, 1'b0);
    chk("req_ready_not_same_cycle", o_req_ready, 1'b0);
    @(negedge clk);
    chk("req_ready_back", o_req_ready, 1'b1);
  endtask

  task automatic issue(input vec_t v);
    int g = 0;
    @(negedge clk);
    sel = v.s;
    #1;
    while (!o_req_ready && g < 10) begin @(negedge clk); g++; end
    chk("req_ready_idle", o_req_ready, 1'b1);
    req_write = v.w; req_byte = v.b; req_addr = v.addr; req_wdata = v.wd;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    req_wdata = $urandom;
  endtask

  task automatic run_txn(input vec_t v);
    issue(v);
    if (!v.mis) begin
      for (int i = 0; i <= v.dly; i++) begin
        @(negedge clk);
        chk("mem_read", o_mem_read, !v.w);
        chk("mem_write", o_mem_write, v.w);
        chk("mem_address", o_mem_addr, v.e_addr);
        if (v.w) begin
          chk("mem_wdata", o_mem_wdata, v.e_wdata);
          chk("mem_byte_enable", o_be, v.e_be);
        end
        if (i == 0) chk("req_ready_busy", o_req_ready, 1'b0);
        chk("resp_valid_early", o_resp_valid, 1'b0);
        if (i == v.dly) begin mem_rdata = v.rd; mem_resp = 1'b1; end
      end
      @(posedge clk); #1 mem_resp = 1'b0; mem_rdata = $urandom;
    end
    @(negedge clk);
    chk("strobe_read_off", o_mem_read, 1'b0);
    chk("strobe_write_off", o_mem_write, 1'b0);
    chk("resp_valid", o_resp_valid, 1'b1);
    chk("resp_rdata", o_resp_rdata, v.e_rdata);
    chk("resp_err", o_resp_err, v.mis);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_valid", o_resp_valid, 1'b1);
      chk("hold_rdata", o_resp_rdata, v.e_rdata);
      chk("hold_req_ready", o_req_ready, 1'b0);
    end
    release_resp();
  endtask

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_rdata = '0; mem_resp = 1'b0;

    tbl[0]  = mk(0,0,0,16'h3000,32'h0,32'hBEEF,2,0, 0,32'hBEEF,16'h3000,32'h0,4'h0);
    tbl[1]  = mk(0,0,1,16'h3001,32'h0,32'hA55A,1,0, 0,32'h00A5,16'h3000,32'h0,4'h0);
    tbl[2]  = mk(0,0,1,16'h3000,32'h0,32'hA55A,0,1, 0,32'h005A,16'h3000,32'h0,4'h0);
    tbl[3]  = mk(0,1,1,16'h4001,32'h1234,32'h0,2,0, 0,32'h0,16'h4000,32'h3434,4'h2);
    tbl[4]  = mk(1,1,0,16'h0102,32'hCAFEF00D,32'h0,0,0, 1,32'h0,16'h0100,32'h0,4'h0);
    tbl[5]  = mk(1,1,0,16'h0104,32'hDEADBEEF,32'h0,1,0, 0,32'h0,16'h0104,32'hDEADBEEF,4'hF);
    tbl[6]  = mk(0,0,0,16'h2001,32'h0,32'h0,0,0, 1,32'h0,16'h2000,32'h0,4'h0);
    tbl[7]  = mk(1,0,1,16'h0103,32'h0,32'h11223344,3,0, 0,32'h11,16'h0100,32'h0,4'h0);
    tbl[8]  = mk(0,0,0,16'h3000,32'h0,32'h1357,1,5, 0,32'h1357,16'h3000,32'h0,4'h0);
    tbl[9]  = mk(1,1,1,16'h0202,32'hAB,32'h0,0,0, 0,32'h0,16'h0200,32'hABABABAB,4'h4);
    tbl[10] = mk(1,0,0,16'h0108,32'h0,32'h89ABCDEF,2,2, 0,32'h89ABCDEF,16'h0108,32'h0,4'h0);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", o_req_ready, 1'b1);
    chk("rst_resp_valid", o_resp_valid, 1'b0);
    chk("rst_mem_read", o_mem_read, 1'b0);
    chk("rst_mem_write", o_mem_write, 1'b0);
    chk("rst_mem_address", o_mem_addr, 16'h0);
    chk("rst_byte_enable", o_be, 4'h0);
    chk("rst_resp_rdata", o_resp_rdata, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Stray mem_resp while idle must not produce a response.
    @(negedge clk);
    sel = 1'b0; mem_resp = 1'b1;
    @(posedge clk); #1 mem_resp = 1'b0;
    @(negedge clk);
    chk("stray_resp_valid", o_resp_valid, 1'b0);
    chk("stray_req_ready", o_req_ready, 1'b1);

    // Asynchronous reset in the middle of an access.
    v = model(0, 0, 0, 16'h3000, 32'h0, 32'h0, 0, 0);
    issue(v);
    @(negedge clk);
    chk("pre_rst_mem_read", o_mem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_read", o_mem_read, 1'b0);
    chk("async_rst_address", o_mem_addr, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", o_req_ready, 1'b1);
    chk("post_rst_resp_valid", o_resp_valid, 1'b0);
    chk("post_rst_mem_read", o_mem_read, 1'b0);

`ifdef MEM_PORT_TIMEOUT_EN
    // No mem_resp: strobe held TMO cycles, then an error response.
    v = model(0, 0, 0, 16'h3000, 32'h0, 32'h0, 0, 0);
    issue(v);
    for (int i = 0; i < int'(TMO); i++) begin
      @(negedge clk);
      chk("tmo_strobe_held", o_mem_read, 1'b1);
    end
    @(negedge clk);
    chk("tmo_strobe_drop", o_mem_read, 1'b0);
    chk("tmo_resp_valid", o_resp_valid, 1'b1);
    chk("tmo_resp_err", o_resp_err, 1'b1);
    chk("tmo_resp_rdata", o_resp_rdata, 32'h0);
    release_resp();
    // mem_resp on the expiry cycle completes normally.
    run_txn(model(0, 0, 0, 16'h3000, 32'h0, 32'h2468, int'(TMO) - 1, 0));
`else
    // Without the timeout the port waits for mem_resp indefinitely.
    v = model(0, 0, 0, 16'h3000, 32'h0, 32'h0, 0, 0);
    issue(v);
    repeat (12) @(negedge clk);
    chk("wait_strobe_held", o_mem_read, 1'b1);
    chk("wait_no_resp", o_resp_valid, 1'b0);
    mem_rdata = 32'h0000_2468; mem_resp = 1'b1;
    @(posedge clk); #1 mem_resp = 1'b0;
    @(negedge clk);
    chk("wait_resp_valid", o_resp_valid, 1'b1);
    chk("wait_resp_rdata", o_resp_rdata, 32'h2468);
    chk("wait_resp_err", o_resp_err, 1'b0);
    release_resp();
`endif

    // Randomised accesses against the reference model.
    for (int n = 0; n < 40; n++) begin
      v = model(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), $urandom, $urandom,
                int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, 2)));
      run_txn(v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
